// File: rtl/decoder_nto2n_seq.sv
// decoder_nto2n_seq: registered N-to-2^N one-hot decoder with enable,
// load-on-strobe direct mode and auto-scan mode with programmable dwell.
// Optional build macro DECODER_ACTIVE_LOW_EN selects active-low Y
// (selected line 0, inactive value all ones); default is active-high.
module decoder_nto2n_seq #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                MODE,
  input  logic                LOAD,
  input  logic [N-1:0]        A,
  output logic [(1<<N)-1:0]   Y,
  output logic [N-1:0]        IDX,
  output logic                VALID,
  output logic                WRAP
);

  localparam int W  = 1 << N;
  localparam int CW = $clog2(DWELL) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};
  localparam logic [N-1:0]  IDX_ONE  = N'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          loaded;

  // Output line pattern for index i; act=0 gives the inactive pattern.
  function automatic logic [W-1:0] decode(input logic [N-1:0] i, input logic act);
    logic [W-1:0] oh;
    oh = '0;
    if (act) oh[i] = 1'b1;
`ifdef DECODER_ACTIVE_LOW_EN
    return ~oh;
`else
    return oh;
`endif
  endfunction

  // Mode FSM with all outputs registered; EN low overrides everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      IDX    <= '0;
      Y      <= decode('0, 1'b0);
      VALID  <= 1'b0;
      WRAP   <= 1'b0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (!EN) begin
      state  <= S_IDLE;
      Y      <= decode(IDX, 1'b0);
      VALID  <= 1'b0;
      WRAP   <= 1'b0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          WRAP <= 1'b0;
          if (MODE) begin
            state <= S_SCAN;
            IDX   <= A;
            cnt   <= '0;
            VALID <= 1'b1;
            Y     <= decode(A, 1'b1);
          end else begin
            state <= S_DIRECT;
            if (LOAD) begin
              IDX    <= A;
              loaded <= 1'b1;
              VALID  <= 1'b1;
              Y      <= decode(A, 1'b1);
            end
          end
        end
        S_DIRECT: begin
          WRAP <= 1'b0;
          if (MODE) begin
            // Continue from the held index unless nothing was loaded yet.
            state <= S_SCAN;
            cnt   <= '0;
            VALID <= 1'b1;
            if (LOAD || !loaded) begin
              IDX <= A;
              Y   <= decode(A, 1'b1);
            end else begin
              Y   <= decode(IDX, 1'b1);
            end
          end else if (LOAD) begin
            IDX    <= A;
            loaded <= 1'b1;
            VALID  <= 1'b1;
            Y      <= decode(A, 1'b1);
          end
        end
        S_SCAN: begin
          if (!MODE) begin
            // Freeze the scan position; it counts as a loaded index.
            state  <= S_DIRECT;
            loaded <= 1'b1;
            VALID  <= 1'b1;
            WRAP   <= 1'b0;
            if (LOAD) begin
              IDX <= A;
              Y   <= decode(A, 1'b1);
            end
          end else if (LOAD) begin
            IDX  <= A;
            cnt  <= '0;
            Y    <= decode(A, 1'b1);
            WRAP <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            IDX  <= IDX + IDX_ONE;
            Y    <= decode(IDX + IDX_ONE, 1'b1);
            WRAP <= (IDX == IDX_LAST);
          end else begin
            cnt  <= cnt + CNT_ONE;
            WRAP <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          VALID <= 1'b0;
          WRAP  <= 1'b0;
          Y     <= decode(IDX, 1'b0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq (N=3, DWELL=4): directed
// scenarios plus randomized traffic against a timeline-based reference.
module tb_decoder_nto2n_seq;

  localparam int N = 3;
  localparam int D = 4;
  localparam int W = 1 << N;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [W-1:0] YMASK = '1;
`else
  localparam logic [W-1:0] YMASK = '0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic         MODE;
  logic         LOAD;
  logic [N-1:0] A;
  logic [W-1:0] Y;
  logic [N-1:0] IDX;
  logic         VALID;
  logic         WRAP;

  int checks = 0;
  int errors = 0;

  decoder_nto2n_seq #(.N(N), .DWELL(D)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .LOAD(LOAD), .A(A),
    .Y(Y), .IDX(IDX), .VALID(VALID), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  // Expected Y pattern: selected line active when v=1, all inactive otherwise.
  function automatic logic [W-1:0] yexp(input int idx, input bit v);
    logic [W-1:0] oh;
    oh = '0;
    if (v) oh = W'(1) << idx;
    return oh ^ YMASK;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; MODE = 1'b0; LOAD = 1'b0; A = '0;
    #2;
    checks++; if (Y !== yexp(0, 0)) begin errors++; $display("FAIL reset_y got %h want %h", Y, yexp(0, 0)); end
    checks++; if (IDX !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", IDX); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", VALID); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", WRAP); end
    tick();
    RST = 1'b0;
    EN = 1'b1; MODE = 1'b1; A = 3'd3;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL midscan_valid got %b want 1", VALID); end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    RST = 1'b1;
    #1;
    checks++; if (Y !== yexp(0, 0)) begin errors++; $display("FAIL async_reset_y got %h want %h", Y, yexp(0, 0)); end
    checks++; if (IDX !== 3'd0) begin errors++; $display("FAIL async_reset_idx got %0d want 0", IDX); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b want 0", VALID); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL async_reset_wrap got %b want 0", WRAP); end
    EN = 1'b0; MODE = 1'b0;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_direct();
    EN = 1'b1; MODE = 1'b0; LOAD = 1'b0; A = 3'd2;
    tick();
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL direct_noload_valid got %b want 0", VALID); end
    checks++; if (Y !== yexp(0, 0)) begin errors++; $display("FAIL direct_noload_y got %h want %h", Y, yexp(0, 0)); end
    LOAD = 1'b1; A = 3'b101;
    tick();
    LOAD = 1'b0;
    checks++; if (Y !== yexp(5, 1)) begin errors++; $display("FAIL direct_y got %h want %h", Y, yexp(5, 1)); end
    checks++; if (IDX !== 3'd5) begin errors++; $display("FAIL direct_idx got %0d want 5", IDX); end
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL direct_valid got %b want 1", VALID); end
    A = 3'd2;
    tick();
    tick();
    checks++; if (Y !== yexp(5, 1)) begin errors++; $display("FAIL direct_hold_y got %h want %h", Y, yexp(5, 1)); end
    checks++; if (IDX !== 3'd5) begin errors++; $display("FAIL direct_hold_idx got %0d want 5", IDX); end
  endtask

  task automatic test_scan_sweep();
    int exp_idx;
    EN = 1'b0;
    tick();
    EN = 1'b1; MODE = 1'b1; LOAD = 1'b0; A = 3'b110;
    tick();
    for (int k = 0; k < 16; k++) begin
      exp_idx = (6 + k / D) % W;
      checks++; if (IDX !== N'(exp_idx)) begin errors++; $display("FAIL sweep_idx k=%0d got %0d want %0d", k, IDX, exp_idx); end
      checks++; if (WRAP !== (k == 8)) begin errors++; $display("FAIL sweep_wrap k=%0d got %b want %b", k, WRAP, (k == 8)); end
      if (k == 8) begin
        checks++; if (Y !== yexp(0, 1)) begin errors++; $display("FAIL sweep_wrap_y got %h want %h", Y, yexp(0, 1)); end
      end
      tick();
    end
  endtask

  task automatic test_scan_jump();
    checks++; if (IDX !== 3'd2) begin errors++; $display("FAIL jump_pre_idx got %0d want 2", IDX); end
    LOAD = 1'b1; A = 3'b000;
    tick();
    LOAD = 1'b0; A = 3'd6;
    for (int j = 0; j < D; j++) begin
      checks++; if (IDX !== 3'd0) begin errors++; $display("FAIL jump_idx j=%0d got %0d want 0", j, IDX); end
      checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL jump_wrap j=%0d got %b want 0", j, WRAP); end
      tick();
    end
    checks++; if (IDX !== 3'd1) begin errors++; $display("FAIL jump_dwell_idx got %0d want 1", IDX); end
  endtask

  task automatic test_enable_priority();
    EN = 1'b0; LOAD = 1'b1; MODE = 1'b1; A = 3'd5;
    tick();
    LOAD = 1'b0;
    checks++; if (Y !== yexp(0, 0)) begin errors++; $display("FAIL en_y got %h want %h", Y, yexp(0, 0)); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL en_valid got %b want 0", VALID); end
    checks++; if (IDX !== 3'd1) begin errors++; $display("FAIL en_idx got %0d want 1", IDX); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL en_wrap got %b want 0", WRAP); end
  endtask

  // Reference: scan position derived from an anchor index and elapsed cycles.
  task automatic test_random();
    int  m_st, m_idx, m_s, m_e;
    bit  m_valid, m_loaded, m_wrap;
    EN = 1'b0; MODE = 1'b0; LOAD = 1'b0; A = '0;
    #2;
    RST = 1'b1;
    #1;
    RST = 1'b0;
    m_st = 0; m_idx = 0; m_s = 0; m_e = 0;
    m_valid = 0; m_loaded = 0; m_wrap = 0;
    for (int c = 0; c < 600; c++) begin
      EN   = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 99) < 8) MODE = ~MODE;
      LOAD = ($urandom_range(0, 99) < 15);
      A    = N'($urandom_range(0, W - 1));
      m_wrap = 0;
      if (!EN) begin
        m_st = 0; m_valid = 0; m_loaded = 0;
      end else if (m_st == 0) begin
        if (MODE) begin
          m_st = 2; m_s = A; m_e = 0; m_idx = A; m_valid = 1;
        end else begin
          m_st = 1;
          if (LOAD) begin m_idx = A; m_loaded = 1; m_valid = 1; end
        end
      end else if (m_st == 1) begin
        if (MODE) begin
          m_st = 2; m_s = (LOAD || !m_loaded) ? int'(A) : m_idx;
          m_e = 0; m_idx = m_s; m_valid = 1;
        end else if (LOAD) begin
          m_idx = A; m_loaded = 1; m_valid = 1;
        end
      end else begin
        if (!MODE) begin
          m_st = 1; m_loaded = 1; m_valid = 1;
          if (LOAD) m_idx = A;
        end else if (LOAD) begin
          m_s = A; m_e = 0; m_idx = A;
        end else begin
          m_e++;
          m_idx = (m_s + m_e / D) % W;
          m_wrap = (m_e % D == 0) && (m_idx == 0);
        end
      end
      tick();
      checks++; if (Y !== yexp(m_idx, m_valid)) begin errors++; $display("FAIL rand_y c=%0d got %h want %h", c, Y, yexp(m_idx, m_valid)); end
      checks++; if (IDX !== N'(m_idx)) begin errors++; $display("FAIL rand_idx c=%0d got %0d want %0d", c, IDX, m_idx); end
      checks++; if (VALID !== m_valid) begin errors++; $display("FAIL rand_valid c=%0d got %b want %b", c, VALID, m_valid); end
      checks++; if (WRAP !== m_wrap) begin errors++; $display("FAIL rand_wrap c=%0d got %b want %b", c, WRAP, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_sweep();
    test_scan_jump();
    test_enable_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
